// File: rtl/eth_sched_pkg.sv
// ---------------------------------------------------------------------------
// eth_sched_pkg
// Shared types and constants for the Ethernet packet scheduler.
//   state_t       : scheduler FSM states
//   HDR_BYTES     : bytes in the frame header (magic, channel, seq hi, seq lo)
//   SEQ_W         : width of the per-packet sequence number
//   CH_W          : width of a channel index (up to 8 requesters)
//   DEFAULT_MAGIC : default value of header byte 0
// ---------------------------------------------------------------------------
package eth_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        HDR,
        PAYLOAD,
        CSUM,
        GAP
    } state_t;

    localparam int         HDR_BYTES     = 4;
    localparam int         SEQ_W         = 16;
    localparam int         CH_W          = 3;
    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/eth_packet_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Searches req starting at ptr+1 (mod N)
// and returns the first requester found.
//   req       in  N     request vector
//   ptr       in  CH_W  index of the previously granted requester
//   gnt       out CH_W  granted index (0 when nothing requests)
//   gnt_valid out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import eth_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt,
    output logic            gnt_valid
);

    // cand[k] is the channel examined k-th in the rotated search order.
    logic [CH_W-1:0] cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand[gi] = CH_W'((int'(ptr) + gi + 1) % N);
        end
    endgenerate

    // Walk the order backwards so the earliest candidate overrides later ones.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && (cand[k] == CH_W'(j))) begin
                    gnt       = cand[k];
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eth_packet_scheduler.sv
// ---------------------------------------------------------------------------
// eth_packet_scheduler
// Shares the UDP transmit path between NUM_CH first-word-fall-through byte
// FIFOs. Each grant produces one contiguous frame: MAGIC, channel, seq[15:8],
// seq[7:0], then PAYLOAD_BYTES payload bytes, followed by at least
// GAP_CYCLES idle cycles.
//
// Build option: define ETH_SCHED_CHECKSUM_EN to append one XOR byte over the
// payload (padding included) after the last payload byte.
//
// Ports
//   clk        in   125 MHz clock
//   rst        in   asynchronous active-high reset
//   enable     in   packets may start while high
//   ch_ready   in   per-channel "a full payload is buffered"
//   ch_empty   in   per-channel FIFO empty
//   ch_dout    in   per-channel FWFT byte, channel i at [8i+7:8i]
//   ch_rd_en   out  one-hot pop strobe
//   tx_valid   out  high for the whole frame
//   tx_data    out  frame byte
//   tx_busy    in   UDP transmitter still sending (checked only in IDLE)
//   active_ch  out  channel of the current / last packet
//   pkt_count  out  packets completed since reset (wraps)
//   underflow  out  sticky: a pop hit an empty FIFO
// ---------------------------------------------------------------------------
module eth_packet_scheduler
    import eth_sched_pkg::*;
#(
    parameter int         NUM_CH        = 4,
    parameter int         PAYLOAD_BYTES = 1024,
    parameter int         GAP_CYCLES    = 16,
    parameter logic [7:0] MAGIC         = DEFAULT_MAGIC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_ready,
    input  logic [NUM_CH-1:0]   ch_empty,
    input  logic [NUM_CH*8-1:0] ch_dout,
    output logic [NUM_CH-1:0]   ch_rd_en,
    output logic                tx_valid,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    output logic [2:0]          active_ch,
    output logic [31:0]         pkt_count,
    output logic                underflow
);

    state_t            state_reg, state_next;
    logic [31:0]       cnt_reg, cnt_next;
    logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CH_W-1:0]   active_ch_reg, active_ch_next;
    logic [SEQ_W-1:0]  seq_reg, seq_next;
    logic [31:0]       pkt_count_reg, pkt_count_next;
    logic              underflow_reg, underflow_next;
    logic [7:0]        tx_data_reg, tx_data_next;
`ifdef ETH_SCHED_CHECKSUM_EN
    logic [7:0]        csum_reg, csum_next;
`endif

    logic [CH_W-1:0]   gnt;
    logic              gnt_valid;
    logic [NUM_CH-1:0] ch_sel;
    logic              sel_empty;
    logic [7:0]        sel_dout;
    logic [7:0]        payload_byte;
    logic              pop_slot;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .req       (ch_ready),
        .ptr       (rr_ptr_reg),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_sel
            assign ch_sel[gi] = (active_ch_reg == CH_W'(gi));
        end
    endgenerate

    assign sel_empty = |(ch_sel & ch_empty);

    always_comb begin
        sel_dout = 8'h00;
        for (int j = 0; j < NUM_CH; j++) begin
            if (ch_sel[j]) begin
                sel_dout = ch_dout[8*j +: 8];
            end
        end
    end

    // An empty FIFO is padded with zero so the frame length never changes.
    assign payload_byte = sel_empty ? 8'h00 : sel_dout;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rr_ptr_next    = rr_ptr_reg;
        active_ch_next = active_ch_reg;
        seq_next       = seq_reg;
        pkt_count_next = pkt_count_reg;
        underflow_next = underflow_reg;
        tx_data_next   = tx_data_reg;
`ifdef ETH_SCHED_CHECKSUM_EN
        csum_next      = csum_reg;
`endif
        pop_slot       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable && !tx_busy && (|ch_ready)) begin
                    state_next = ARB;
                end
            end

            ARB: begin
                // A request that vanished since IDLE simply aborts the grant.
                if (gnt_valid) begin
                    active_ch_next = gnt;
                    rr_ptr_next    = gnt;
                    tx_data_next   = MAGIC;
                    cnt_next       = '0;
`ifdef ETH_SCHED_CHECKSUM_EN
                    csum_next      = 8'h00;
`endif
                    state_next     = HDR;
                end else begin
                    state_next = IDLE;
                end
            end

            // tx_data is a register, so each state cycle loads the byte shown
            // next. The last header cycle therefore already pops payload byte 0,
            // which lets it follow header byte 3 without a bubble.
            HDR: begin
                cnt_next = cnt_reg + 32'd1;
                if (cnt_reg == 32'd0) begin
                    tx_data_next = {5'b0, active_ch_reg};
                end else if (cnt_reg == 32'd1) begin
                    tx_data_next = seq_reg[SEQ_W-1 -: 8];
                end else if (cnt_reg == 32'd2) begin
                    tx_data_next = seq_reg[7:0];
                end else if (cnt_reg == 32'(HDR_BYTES - 1)) begin
                    pop_slot     = 1'b1;
                    tx_data_next = payload_byte;
                    cnt_next     = '0;
                    state_next   = PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (cnt_reg == 32'(PAYLOAD_BYTES - 1)) begin
`ifdef ETH_SCHED_CHECKSUM_EN
                    tx_data_next   = csum_reg;
                    state_next     = CSUM;
`else
                    tx_data_next   = 8'h00;
                    cnt_next       = '0;
                    pkt_count_next = pkt_count_reg + 32'd1;
                    seq_next       = seq_reg + 16'd1;
                    state_next     = GAP;
`endif
                end else begin
                    pop_slot     = 1'b1;
                    tx_data_next = payload_byte;
                    cnt_next     = cnt_reg + 32'd1;
                end
            end

`ifdef ETH_SCHED_CHECKSUM_EN
            CSUM: begin
                tx_data_next   = 8'h00;
                cnt_next       = '0;
                pkt_count_next = pkt_count_reg + 32'd1;
                seq_next       = seq_reg + 16'd1;
                state_next     = GAP;
            end
`endif

            GAP: begin
                if (cnt_reg == 32'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (pop_slot) begin
            if (sel_empty) begin
                underflow_next = 1'b1;
            end
`ifdef ETH_SCHED_CHECKSUM_EN
            csum_next = csum_next ^ payload_byte;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rr_ptr_reg    <= CH_W'(NUM_CH - 1);
            active_ch_reg <= '0;
            seq_reg       <= '0;
            pkt_count_reg <= '0;
            underflow_reg <= 1'b0;
            tx_data_reg   <= 8'h00;
`ifdef ETH_SCHED_CHECKSUM_EN
            csum_reg      <= 8'h00;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rr_ptr_reg    <= rr_ptr_next;
            active_ch_reg <= active_ch_next;
            seq_reg       <= seq_next;
            pkt_count_reg <= pkt_count_next;
            underflow_reg <= underflow_next;
            tx_data_reg   <= tx_data_next;
`ifdef ETH_SCHED_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    // Pops are suppressed on an empty FIFO; the byte is padded instead.
    assign ch_rd_en  = (pop_slot && !sel_empty) ? ch_sel : '0;
`ifdef ETH_SCHED_CHECKSUM_EN
    assign tx_valid  = (state_reg == HDR) || (state_reg == PAYLOAD) || (state_reg == CSUM);
`else
    assign tx_valid  = (state_reg == HDR) || (state_reg == PAYLOAD);
`endif
    assign tx_data   = tx_data_reg;
    assign active_ch = active_ch_reg;
    assign pkt_count = pkt_count_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_eth_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_eth_packet_scheduler
// Directed bench for eth_packet_scheduler with NUM_CH=4, PAYLOAD_BYTES=8,
// GAP_CYCLES=4. FIFOs are modelled as byte queues; frames are captured from
// tx_valid/tx_data and compared with frames built from the FIFO contents.
// ---------------------------------------------------------------------------
module tb_eth_packet_scheduler;

    localparam int NCH = 4;
    localparam int PB  = 8;
    localparam int GAP = 4;
`ifdef ETH_SCHED_CHECKSUM_EN
    localparam int FL  = 5 + PB;
`else
    localparam int FL  = 4 + PB;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             tx_busy = 1'b0;
    logic [NCH-1:0]   ch_ready = '0;
    logic [NCH-1:0]   ch_empty;
    logic [NCH*8-1:0] ch_dout;
    logic [NCH-1:0]   ch_rd_en;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic [2:0]       active_ch;
    logic [31:0]      pkt_count;
    logic             underflow;

    eth_packet_scheduler #(
        .NUM_CH        (NCH),
        .PAYLOAD_BYTES (PB),
        .GAP_CYCLES    (GAP),
        .MAGIC         (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ch_ready  (ch_ready),
        .ch_empty  (ch_empty),
        .ch_dout   (ch_dout),
        .ch_rd_en  (ch_rd_en),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .active_ch (active_ch),
        .pkt_count (pkt_count),
        .underflow (underflow)
    );

    always #4 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ---------------- FIFO model ----------------
    logic [7:0]     fifo [NCH][$];
    logic [NCH-1:0] empty_force = '0;
    int             pop_cnt [NCH];
    int             pat_cnt [NCH];

    function automatic void update_view();
        for (int i = 0; i < NCH; i++) begin
            ch_empty[i]      = (fifo[i].size() == 0) || empty_force[i];
            ch_dout[8*i +: 8] = (fifo[i].size() > 0) ? fifo[i][0] : 8'h00;
        end
    endfunction

    always @(posedge clk) begin
        logic [NCH-1:0] p;
        p = ch_rd_en;
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (p[i]) begin
                if (fifo[i].size() > 0) void'(fifo[i].pop_front());
                pop_cnt[i]++;
            end
        end
        update_view();
    end

    // ---------------- frame monitor ----------------
    logic [7:0] cur [$];
    logic [7:0] last_frame [$];
    logic [7:0] exp_frame [$];
    logic [7:0] exp_pay [$];
    int         frame_cnt  = 0;
    int         low_run    = 0;
    int         gap_before = 0;
    int         bad_rd     = 0;
    logic [2:0] last_ch    = '0;
    logic [31:0] last_pkt  = '0;

    always @(negedge clk) begin
        if (rst) begin
            cur.delete();
            low_run = 0;
        end else begin
            if ((ch_rd_en != '0) && !tx_valid) bad_rd++;
            if ($countones(ch_rd_en) > 1) bad_rd++;
            if (tx_valid) begin
                if (cur.size() == 0) gap_before = low_run;
                cur.push_back(tx_data);
                low_run = 0;
            end else begin
                low_run++;
                if (cur.size() != 0) begin
                    last_frame = cur;
                    last_ch    = active_ch;
                    last_pkt   = pkt_count;
                    frame_cnt++;
                    cur.delete();
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_pat(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            fifo[c].push_back(8'((c << 5) | (pat_cnt[c] & 31)));
            pat_cnt[c]++;
        end
        update_view();
    endtask

    task automatic snap(input int c);
        exp_pay.delete();
        for (int k = 0; k < PB; k++) exp_pay.push_back(fifo[c][k]);
    endtask

    task automatic build_exp(input logic [2:0] c, input logic [15:0] s);
        exp_frame.delete();
        exp_frame.push_back(8'hA5);
        exp_frame.push_back({5'b0, c});
        exp_frame.push_back(s[15:8]);
        exp_frame.push_back(s[7:0]);
        foreach (exp_pay[k]) exp_frame.push_back(exp_pay[k]);
`ifdef ETH_SCHED_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (exp_pay[k]) x ^= exp_pay[k];
            exp_frame.push_back(x);
        end
`endif
    endtask

    task automatic compare_frame(input string name);
        int nmis;
        nmis = 0;
        chk({name, "_len"}, last_frame.size(), exp_frame.size());
        for (int k = 0; k < exp_frame.size() && k < last_frame.size(); k++)
            if (last_frame[k] !== exp_frame[k]) nmis++;
        chk({name, "_bad_bytes"}, nmis, 0);
    endtask

    // Returns at the first negedge where tx_valid is high; lat counts negedges.
    task automatic wait_start(input string name, output int lat);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (tx_valid) return;
        end
        chk({name, "_start_timeout"}, 1, 0);
    endtask

    task automatic wait_done(input string name, input int target);
        int n;
        n = 0;
        while ((frame_cnt < target) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        if (frame_cnt < target) chk({name, "_done_timeout"}, frame_cnt, target);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NCH-1:0] ready;
        int             exp_ch;
        int             exp_seq;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int lat;
        int nv;

        vecs[0]  = '{4'b1111, 0, 0};
        vecs[1]  = '{4'b1111, 1, 1};
        vecs[2]  = '{4'b1111, 2, 2};
        vecs[3]  = '{4'b1111, 3, 3};
        vecs[4]  = '{4'b1111, 0, 4};
        vecs[5]  = '{4'b1111, 1, 5};
        vecs[6]  = '{4'b1010, 3, 6};
        vecs[7]  = '{4'b1010, 1, 7};
        vecs[8]  = '{4'b1010, 3, 8};
        vecs[9]  = '{4'b0001, 0, 9};
        vecs[10] = '{4'b0110, 1, 10};
        vecs[11] = '{4'b0110, 2, 11};

        for (int i = 0; i < NCH; i++) begin
            pop_cnt[i] = 0;
            pat_cnt[i] = 0;
        end
        update_view();

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rd_en", ch_rd_en, 0);
        chk("rst_active_ch", active_ch, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_underflow", underflow, 0);
        rst = 1'b0;

        // ---- single channel 2, enable gating, latency ----
        for (int k = 0; k < PB; k++) fifo[2].push_back(8'(8'h10 + k));
        update_view();
        snap(2);
        ch_ready = 4'b0100;
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid) nv++;
        end
        chk("enable_low_hold", nv, 0);
        enable = 1'b1;
        wait_start("single", lat);
        chk("single_latency", lat, 2);
        ch_ready = '0;
        wait_done("single", 1);
        build_exp(3'd2, 16'd0);
        compare_frame("single");
        chk("single_ch", last_ch, 2);
        chk("single_pops", pop_cnt[2], PB);
        chk("single_pkt_count", last_pkt, 1);
        chk("single_fifo_left", fifo[2].size(), 0);
        chk("single_underflow", underflow, 0);

        // ---- tx_busy holds off the start ----
        push_pat(0, PB);
        snap(0);
        tx_busy  = 1'b1;
        ch_ready = 4'b0001;
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid) nv++;
        end
        chk("busy_hold", nv, 0);
        tx_busy = 1'b0;
        wait_start("busy", lat);
        chk("busy_latency", lat, 2);
        ch_ready = '0;
        wait_done("busy", 2);
        build_exp(3'd0, 16'd1);
        compare_frame("busy");
        chk("busy_pkt_count", last_pkt, 2);

        // ---- underflow on payload bytes 3 and 4 of channel 1 ----
        fifo[1].delete();
        for (int k = 0; k < PB; k++) fifo[1].push_back(8'(8'h20 + k));
        update_view();
        pop_cnt[1] = 0;
        ch_ready = 4'b0010;
        wait_start("uflow", lat);
        ch_ready = '0;
        repeat (6) @(posedge clk);
        #1;
        empty_force[1] = 1'b1;
        update_view();
        repeat (2) @(posedge clk);
        #1;
        empty_force[1] = 1'b0;
        update_view();
        wait_done("uflow", 3);
        exp_pay.delete();
        exp_pay.push_back(8'h20); exp_pay.push_back(8'h21); exp_pay.push_back(8'h22);
        exp_pay.push_back(8'h00); exp_pay.push_back(8'h00);
        exp_pay.push_back(8'h23); exp_pay.push_back(8'h24); exp_pay.push_back(8'h25);
        build_exp(3'd1, 16'd2);
        compare_frame("uflow");
        chk("uflow_pops", pop_cnt[1], 6);
        chk("uflow_flag", underflow, 1);
        chk("uflow_pkt_count", last_pkt, 3);

        // ---- reset during payload byte 5 ----
        for (int k = 0; k < PB; k++) fifo[2].push_back(8'(8'h40 + k));
        update_view();
        ch_ready = 4'b0100;
        wait_start("rstmid", lat);
        ch_ready = '0;
        chk("uflow_sticky", underflow, 1);
        repeat (9) @(posedge clk);
        #1;
        chk("rstmid_byte5", tx_data, 8'h45);
        rst = 1'b1;
        #1;
        chk("rstmid_tx_valid", tx_valid, 0);
        chk("rstmid_rd_en", ch_rd_en, 0);
        chk("rstmid_pkt_count", pkt_count, 0);
        chk("rstmid_underflow", underflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---- round-robin table ----
        for (int v = 0; v < 12; v++) begin
            ch_ready = vecs[v].ready;
            for (int i = 0; i < NCH; i++)
                if (fifo[i].size() < 2 * PB) push_pat(i, 2 * PB - fifo[i].size());
            snap(vecs[v].exp_ch);
            wait_done("tbl", frame_cnt + 1);
            $display("[TB] rr vec %0d ready=%b ch=%0d seq=%0d len=%0d", v, vecs[v].ready,
                     last_ch, vecs[v].exp_seq, last_frame.size());
            chk("tbl_ch", last_ch, vecs[v].exp_ch);
            build_exp(3'(vecs[v].exp_ch), 16'(vecs[v].exp_seq));
            compare_frame("tbl");
            chk("tbl_pkt_count", last_pkt, vecs[v].exp_seq + 1);
            if (v > 0) chk("tbl_gap", (gap_before >= GAP), 1);
        end
        ch_ready = '0;

        // ---- sequence wrap ----
        push_pat(0, 2 * PB);
        snap(0);
        force dut.seq_reg = 16'hFFFF;
        ch_ready = 4'b0001;
        wait_start("wrap", lat);
        release dut.seq_reg;
        wait_done("wrap", frame_cnt + 1);
        build_exp(3'd0, 16'hFFFF);
        compare_frame("wrap_ffff");
        snap(0);
        wait_done("wrap", frame_cnt + 1);
        ch_ready = '0;
        build_exp(3'd0, 16'h0000);
        compare_frame("wrap_0000");

`ifdef ETH_SCHED_CHECKSUM_EN
        // ---- checksum byte ----
        fifo[0].delete();
        fifo[0].push_back(8'h01); fifo[0].push_back(8'h02);
        fifo[0].push_back(8'h04); fifo[0].push_back(8'h08);
        for (int k = 4; k < PB; k++) fifo[0].push_back(8'h00);
        update_view();
        ch_ready = 4'b0001;
        wait_start("csum", lat);
        ch_ready = '0;
        wait_done("csum", frame_cnt + 1);
        chk("csum_len", last_frame.size(), FL);
        if (last_frame.size() == FL) chk("csum_byte", last_frame[FL-1], 8'h0F);
`endif

        chk("rd_en_window", bad_rd, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
